// File: rtl/otp_lci_macro_resp.sv
`timescale 1ns / 1ps
// otp_lci_macro_resp
// Responder end of the OTP native command interface used by the LCI
// initiator. It holds a small write-once word array where bits can only
// ever be set. It grants single-word read/write commands, answers after a
// fixed latency, and reports prim_otp_pkg-style error codes.
//
// Optional build macro: OTP_LCI_MACRO_RESP_FAULT_INJ_EN
//   Adds fault_en_i / fault_addr_i. A write to fault_addr_i that is granted
//   while fault_en_i is high still programs the word, but it reports
//   MacroError.
//
// FSM states:
//   state   | meaning
//   --------+--------------------------------------------------------------
//   IdleSt  | no command outstanding; grant follows otp_req_i
//   WaitSt  | command captured; latency counter running
//   RespSt  | rvalid pulse with err/rdata; a write commits at the end of it
//   ErrorSt | invalid state encoding seen; frozen until reset
module otp_lci_macro_resp #(
  parameter int NumWords   = 64,
  parameter int AddrWidth  = 11,
  parameter int BaseAddr   = 0,
  parameter int RspLatency = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 otp_req_i,
  input  logic [2:0]           otp_cmd_i,
  input  logic [1:0]           otp_size_i,
  input  logic [AddrWidth-1:0] otp_addr_i,
  input  logic [31:0]          otp_wdata_i,
`ifdef OTP_LCI_MACRO_RESP_FAULT_INJ_EN
  input  logic                 fault_en_i,
  input  logic [AddrWidth-1:0] fault_addr_i,
`endif
  output logic                 otp_gnt_o,
  output logic                 otp_rvalid_o,
  output logic [63:0]          otp_rdata_o,
  output logic [2:0]           otp_err_o,
  output logic                 busy_o
);

  localparam int                   IdxWidth  = $clog2(NumWords);
  localparam logic [AddrWidth-1:0] BaseAddrW = AddrWidth'(BaseAddr);
  localparam logic [AddrWidth:0]   NumWordsW = (AddrWidth + 1)'(NumWords);
  localparam logic [3:0]           CntLoad   = 4'(RspLatency - 1);

  localparam logic [2:0] CmdRead       = 3'b000;
  localparam logic [2:0] CmdWrite      = 3'b001;
  localparam logic [2:0] ErrNone       = 3'd0;
  localparam logic [2:0] ErrMacro      = 3'd1;
  localparam logic [2:0] ErrWriteBlank = 3'd4;

  // Every pair of encodings differs in at least three bits.
  typedef enum logic [4:0] {
    IdleSt  = 5'b00000,
    WaitSt  = 5'b00111,
    RespSt  = 5'b11001,
    ErrorSt = 5'b11110
  } state_e;

  state_e               state_q;
  logic [3:0]           cnt_q;
  logic [2:0]           cmd_q;
  logic [1:0]           size_q;
  logic [AddrWidth-1:0] addr_q;
  logic [15:0]          wdata_q;
  logic                 wr_en_q;
  logic                 rvalid_q;
  logic [63:0]          rdata_q;
  logic [2:0]           err_q;
  logic                 busy_q;

  logic [15:0] mem_q [NumWords];

  // Only the low halfword of the write data is ever stored.
  logic unused_wdata;
  assign unused_wdata = ^otp_wdata_i[31:16];

  // Response inputs: the live command when answering straight from IdleSt
  // (RspLatency of 1), otherwise the captured command.
  logic [2:0]           r_cmd;
  logic [1:0]           r_size;
  logic [AddrWidth-1:0] r_addr;
  logic [15:0]          r_wdata;
  logic                 r_fault;

`ifdef OTP_LCI_MACRO_RESP_FAULT_INJ_EN
  logic fault_q;
  logic fault_hit;
  assign fault_hit = fault_en_i && (otp_addr_i == fault_addr_i);
`endif

  // Select the live or the captured command for response evaluation.
  always_comb begin
    r_cmd   = cmd_q;
    r_size  = size_q;
    r_addr  = addr_q;
    r_wdata = wdata_q;
    if (state_q == IdleSt) begin
      r_cmd   = otp_cmd_i;
      r_size  = otp_size_i;
      r_addr  = otp_addr_i;
      r_wdata = otp_wdata_i[15:0];
    end
  end

`ifdef OTP_LCI_MACRO_RESP_FAULT_INJ_EN
  assign r_fault = (state_q == IdleSt) ? fault_hit : fault_q;
`else
  assign r_fault = 1'b0;
`endif

  logic [AddrWidth-1:0] r_idx_full;
  logic [IdxWidth-1:0]  r_idx;
  logic                 r_oor;
  logic                 r_illegal;
  logic [15:0]          r_old;

  // The index wraps modulo 2^AddrWidth, so an address below the base is
  // out of range.
  assign r_idx_full = r_addr - BaseAddrW;
  assign r_idx      = r_idx_full[IdxWidth-1:0];
  assign r_oor      = {1'b0, r_idx_full} >= NumWordsW;
  assign r_illegal  = ((r_cmd != CmdRead) && (r_cmd != CmdWrite)) ||
                      (r_size != 2'd0) || r_oor;
  assign r_old      = mem_q[r_idx];

  logic [2:0]  r_err;
  logic [63:0] r_rdata;
  logic        r_wr_en;

  // Evaluate error code, read data and write permission for the response.
  always_comb begin
    r_err   = ErrNone;
    r_rdata = '0;
    r_wr_en = 1'b0;
    if (r_illegal) begin
      r_err = ErrMacro;
    end else if (r_cmd == CmdRead) begin
      r_rdata = {48'b0, r_old};
    end else begin
      r_wr_en = 1'b1;
      if (r_fault) begin
        r_err = ErrMacro;
      end else if (|(r_old & ~r_wdata)) begin
        r_err = ErrWriteBlank;
      end
    end
  end

  assign otp_gnt_o = (state_q == IdleSt) && otp_req_i;

  // Control FSM with registered response outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IdleSt;
      cnt_q    <= '0;
      cmd_q    <= '0;
      size_q   <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wr_en_q  <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= '0;
      wr_en_q  <= 1'b0;
      case (state_q)
        IdleSt: begin
          busy_q <= 1'b0;
          if (otp_req_i) begin
            cmd_q   <= otp_cmd_i;
            size_q  <= otp_size_i;
            addr_q  <= otp_addr_i;
            wdata_q <= otp_wdata_i[15:0];
            cnt_q   <= CntLoad;
            busy_q  <= 1'b1;
            if (RspLatency == 1) begin
              state_q  <= RespSt;
              rvalid_q <= 1'b1;
              rdata_q  <= r_rdata;
              err_q    <= r_err;
              wr_en_q  <= r_wr_en;
            end else begin
              state_q <= WaitSt;
            end
          end
        end
        WaitSt: begin
          busy_q <= 1'b1;
          cnt_q  <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q  <= RespSt;
            rvalid_q <= 1'b1;
            rdata_q  <= r_rdata;
            err_q    <= r_err;
            wr_en_q  <= r_wr_en;
          end
        end
        RespSt: begin
          state_q <= IdleSt;
          busy_q  <= 1'b0;
        end
        ErrorSt: begin
          busy_q <= 1'b1;
        end
        default: begin
          state_q <= ErrorSt;
          busy_q  <= 1'b1;
        end
      endcase
    end
  end

`ifdef OTP_LCI_MACRO_RESP_FAULT_INJ_EN
  // Fault hit is sampled at grant, like the rest of the command.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fault_q <= 1'b0;
    end else if (otp_gnt_o) begin
      fault_q <= fault_hit;
    end
  end
`endif

  // Write-once array: a legal write ORs new bits in during the response cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NumWords; i++) begin
        mem_q[i] <= '0;
      end
    end else if ((state_q == RespSt) && wr_en_q) begin
      mem_q[r_idx] <= r_old | r_wdata;
    end
  end

  assign otp_rvalid_o = rvalid_q;
  assign otp_rdata_o  = rdata_q;
  assign otp_err_o    = err_q;
  assign busy_o       = busy_q;

endmodule

// File: tb/tb_otp_lci_macro_resp.sv
`timescale 1ns / 1ps
// Scoreboard bench for otp_lci_macro_resp: expected responses come from a
// local write-once model and are queued at grant, then popped on rvalid.
module tb_otp_lci_macro_resp;

  localparam int NumWords   = 64;
  localparam int AddrWidth  = 11;
  localparam int BaseAddr   = 8;
  localparam int RspLatency = 2;

  logic                 clk_i = 1'b0;
  logic                 rst_i = 1'b1;
  logic                 otp_req_i = 1'b0;
  logic [2:0]           otp_cmd_i = '0;
  logic [1:0]           otp_size_i = '0;
  logic [AddrWidth-1:0] otp_addr_i = '0;
  logic [31:0]          otp_wdata_i = '0;
`ifdef OTP_LCI_MACRO_RESP_FAULT_INJ_EN
  logic                 fault_en_i = 1'b0;
  logic [AddrWidth-1:0] fault_addr_i = '0;
`endif
  logic                 otp_gnt_o;
  logic                 otp_rvalid_o;
  logic [63:0]          otp_rdata_o;
  logic [2:0]           otp_err_o;
  logic                 busy_o;

  otp_lci_macro_resp #(
    .NumWords  (NumWords),
    .AddrWidth (AddrWidth),
    .BaseAddr  (BaseAddr),
    .RspLatency(RspLatency)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .otp_req_i   (otp_req_i),
    .otp_cmd_i   (otp_cmd_i),
    .otp_size_i  (otp_size_i),
    .otp_addr_i  (otp_addr_i),
    .otp_wdata_i (otp_wdata_i),
`ifdef OTP_LCI_MACRO_RESP_FAULT_INJ_EN
    .fault_en_i  (fault_en_i),
    .fault_addr_i(fault_addr_i),
`endif
    .otp_gnt_o   (otp_gnt_o),
    .otp_rvalid_o(otp_rvalid_o),
    .otp_rdata_o (otp_rdata_o),
    .otp_err_o   (otp_err_o),
    .busy_o      (busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    string       tag;
    logic [63:0] rdata;
    logic [2:0]  err;
    logic        chk_rdata;
    int          gnt_cyc;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] mem_m [NumWords];
  int          cyc = 0;
  int          last_rv_cyc = -10;
  int          n_checks = 0;
  int          n_pass = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [AddrWidth-1:0] a_of(input int off);
    return AddrWidth'(BaseAddr + off);
  endfunction

  always @(negedge clk_i) begin : mon
    exp_t e;
    if (!rst_i && otp_rvalid_o) begin
      if (sb.size() == 0) begin
        chk("unexpected_rvalid", 64'(otp_rvalid_o), 64'd0);
      end else begin
        e = sb.pop_front();
        chk({e.tag, "_err"}, 64'(otp_err_o), 64'(e.err));
        if (e.chk_rdata) chk({e.tag, "_rdata"}, otp_rdata_o, e.rdata);
        chk({e.tag, "_latency"}, 64'(cyc - e.gnt_cyc), 64'(RspLatency));
      end
      last_rv_cyc = cyc;
    end
  end

  task automatic issue(input string tag, input logic [2:0] cmd, input logic [1:0] size,
                       input logic [AddrWidth-1:0] addr, input logic [15:0] wd,
                       input logic fault);
    exp_t                 e;
    logic [AddrWidth-1:0] idx;
    logic [15:0]          old;
    int                   n;
    idx         = addr - AddrWidth'(BaseAddr);
    e.tag       = tag;
    e.rdata     = '0;
    e.err       = 3'd0;
    e.chk_rdata = 1'b1;
    if (cmd > 3'd1 || size != 2'd0 || int'(idx) >= NumWords) begin
      e.err = 3'd1;
    end else if (cmd == 3'd0) begin
      e.rdata = {48'b0, mem_m[idx[5:0]]};
    end else begin
      old         = mem_m[idx[5:0]];
      e.chk_rdata = 1'b0;
      if (fault) e.err = 3'd1;
      else if ((old & ~wd) != 16'h0) e.err = 3'd4;
      mem_m[idx[5:0]] = old | wd;
    end
    @(negedge clk_i);
    otp_req_i   = 1'b1;
    otp_cmd_i   = cmd;
    otp_size_i  = size;
    otp_addr_i  = addr;
    otp_wdata_i = {16'hDEAD, wd};
    n = 0;
    #1;
    while (!otp_gnt_o) begin
      if (n == 100) begin
        chk({tag, "_gnt_timeout"}, 64'd0, 64'd1);
        otp_req_i = 1'b0;
        return;
      end
      @(negedge clk_i);
      #1;
      n++;
    end
    chk({tag, "_no_overlap"}, 64'(sb.size() == 0 && cyc > last_rv_cyc), 64'd1);
    e.gnt_cyc = cyc;
    sb.push_back(e);
    @(posedge clk_i);
    #1;
    otp_req_i = 1'b0;
    chk({tag, "_busy"}, 64'(busy_o), 64'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk_i);
      n++;
    end
    chk("drain", 64'(sb.size()), 64'd0);
    @(negedge clk_i);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NumWords; i++) mem_m[i] = 16'h0;
    repeat (3) @(negedge clk_i);
    chk("rst_gnt",    64'(otp_gnt_o),    64'd0);
    chk("rst_rvalid", 64'(otp_rvalid_o), 64'd0);
    chk("rst_rdata",  otp_rdata_o,       64'd0);
    chk("rst_err",    64'(otp_err_o),    64'd0);
    chk("rst_busy",   64'(busy_o),       64'd0);
    rst_i = 1'b0;

    issue("wr3",      3'b001, 2'd0, a_of(3), 16'h00A5, 1'b0);
    issue("rd3",      3'b000, 2'd0, a_of(3), 16'h0000, 1'b0);
    issue("wr_blank", 3'b001, 2'd0, a_of(3), 16'h00F0, 1'b0);
    issue("rd_f5",    3'b000, 2'd0, a_of(3), 16'h0000, 1'b0);
    issue("wr_same",  3'b001, 2'd0, a_of(3), 16'h00F5, 1'b0);
    issue("rd_same",  3'b000, 2'd0, a_of(3), 16'h0000, 1'b0);
    issue("rd_oor",   3'b000, 2'd0, a_of(NumWords), 16'h0000, 1'b0);
    issue("cmd_ill",  3'b010, 2'd0, a_of(3), 16'hFFFF, 1'b0);
    issue("size_ill", 3'b001, 2'd1, a_of(3), 16'hFFFF, 1'b0);
    issue("below",    3'b001, 2'd0, a_of(-1), 16'hFFFF, 1'b0);
    issue("rd_kept",  3'b000, 2'd0, a_of(3), 16'h0000, 1'b0);
    issue("wr_last",  3'b001, 2'd0, a_of(NumWords - 1), 16'h8001, 1'b0);
    issue("rd_last",  3'b000, 2'd0, a_of(NumWords - 1), 16'h0000, 1'b0);
    drain();

    for (int i = 0; i < 6; i++)
      issue($sformatf("bw%0d", i), 3'b001, 2'd0, a_of(i), 16'(16'h1111 * i), 1'b0);
    for (int i = 0; i < 6; i++)
      issue($sformatf("br%0d", i), 3'b000, 2'd0, a_of(i), 16'h0000, 1'b0);
    drain();

    issue("wr2_rst", 3'b001, 2'd0, a_of(2), 16'hABCD, 1'b0);
    rst_i = 1'b1;
    #1;
    chk("midrst_rvalid", 64'(otp_rvalid_o), 64'd0);
    chk("midrst_busy",   64'(busy_o),       64'd0);
    chk("midrst_err",    64'(otp_err_o),    64'd0);
    sb.delete();
    for (int i = 0; i < NumWords; i++) mem_m[i] = 16'h0;
    @(negedge clk_i);
    rst_i = 1'b0;
    issue("rd2_after_rst", 3'b000, 2'd0, a_of(2), 16'h0000, 1'b0);
    drain();

`ifdef OTP_LCI_MACRO_RESP_FAULT_INJ_EN
    fault_en_i   = 1'b1;
    fault_addr_i = a_of(5);
    issue("wr_fault", 3'b001, 2'd0, a_of(5), 16'h0F0F, 1'b1);
    issue("wr_nofault", 3'b001, 2'd0, a_of(6), 16'h0F0F, 1'b0);
    fault_en_i   = 1'b0;
    issue("rd_fault", 3'b000, 2'd0, a_of(5), 16'h0000, 1'b0);
    drain();
`endif

    repeat (3) @(negedge clk_i);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
